smoke_run_ctrl: RTL and testbench

Cycle-run scheduler for the smoke co-simulation environment. Up to N_REQ requesters (RPC endpoint proxies, in-HDL sequencers) each ask to advance simulated time by a given number of `clock` cycles. The block grants one request at a time in round-robin order, drives `run_en` for exactly that many cycles, and returns a completion token carrying the requester id and any unconsumed cycles. `run_en` feeds the testbench clock gate, so the DUT sees only scheduled cycles.

---
 rtl/smoke_run_ctrl_pkg.sv | 19 +
 rtl/smoke_rr_arb.sv | 43 ++++
 rtl/smoke_run_ctrl.sv | 105 ++++++++++
 tb/tb_smoke_run_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smoke_run_ctrl_pkg.sv
// Shared types and default widths for the smoke co-simulation run scheduler.
package smoke_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  localparam int CNT_W_DEF = 32;
  localparam int N_REQ_DEF = 2;
  localparam int TOT_W_DEF = 64;

  // Id width for n requesters; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smoke_rr_arb.sv
// Round-robin arbiter: searches from the requester after the last grant,
// and moves its pointer only when the owner reports an accepted grant.
module smoke_rr_arb #(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;

  // First asserted request in rotation order starting at ptr wins.
  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    grant_any    = 1'b0;
    idx          = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % N_REQ);
      if (!grant_any && req[idx]) begin
        grant_any         = 1'b1;
        grant_id          = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_any) begin
      ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/smoke_run_ctrl.sv
// Cycle-run scheduler: grants one requester at a time, enables the DUT clock
// for the requested number of cycles, then hands back a completion token.
module smoke_run_ctrl
  import smoke_run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_width(N_REQ),
  parameter int TOT_W = TOT_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CNT_W-1:0] req_cycles,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   halt,
  output logic                   run_en,
  output logic                   busy,
  output logic                   done_valid,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       done_remain,
  input  logic                   done_ready,
  output logic [TOT_W-1:0]       cycles_total
);

  run_state_e       state;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] granted_count;
  logic [N_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic             advance;

  assign advance = (state == IDLE) && !reset;

  smoke_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clock        (clock),
    .reset        (reset),
    .req          (req_valid),
    .advance      (advance),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .grant_any    (grant_any)
  );

  always_comb begin
    granted_count = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) granted_count = req_cycles[i*CNT_W +: CNT_W];
    end
  end

  // A halted cycle never reaches the DUT, so halt gates run_en directly.
  assign req_ready  = advance ? grant_onehot : '0;
  assign run_en     = (state == RUN) && !halt;
  assign busy       = (state != IDLE);
  assign done_valid = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      remain       <= '0;
      done_id      <= '0;
      done_remain  <= '0;
      cycles_total <= '0;
    end else begin
      if (run_en) cycles_total <= cycles_total + TOT_W'(1);
      case (state)
        IDLE: begin
          if (grant_any) begin
            done_id <= grant_id;
            if (granted_count == '0) begin
              done_remain <= '0;
              state       <= DONE;
            end else begin
              remain <= granted_count;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (halt) begin
            done_remain <= remain;
            remain      <= '0;
            state       <= DONE;
          end else if (remain == CNT_W'(1)) begin
            done_remain <= '0;
            remain      <= '0;
            state       <= DONE;
          end else begin
            remain <= remain - CNT_W'(1);
          end
        end
        DONE: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smoke_run_ctrl.sv
// Self-checking bench for smoke_run_ctrl: directed test-plan scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_smoke_run_ctrl;

  localparam int CNT_W = 32;
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;
  localparam int TOT_W = 64;

  logic                   clock;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*CNT_W-1:0] req_cycles;
  logic [N_REQ-1:0]       req_ready;
  logic                   halt;
  logic                   run_en;
  logic                   busy;
  logic                   done_valid;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       done_remain;
  logic                   done_ready;
  logic [TOT_W-1:0]       cycles_total;

  int n_checks = 0;
  int n_fails  = 0;

  smoke_run_ctrl #(
    .CNT_W (CNT_W),
    .N_REQ (N_REQ),
    .ID_W  (ID_W),
    .TOT_W (TOT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_cycles   (req_cycles),
    .req_ready    (req_ready),
    .halt         (halt),
    .run_en       (run_en),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .done_remain  (done_remain),
    .done_ready   (done_ready),
    .cycles_total (cycles_total)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: cycles still owed to the current job, a pending token,
  // the rotation start point and the running total of enabled cycles.
  longint      m_run_left = 0;
  bit          m_tok      = 0;
  int          m_tok_id   = 0;
  longint      m_tok_rem  = 0;
  int          m_job      = 0;
  int          m_ptr      = 0;
  logic [63:0] m_total    = '0;
  logic [N_REQ-1:0] hs_mask = '0;
  int          grant_log[$];

  always @(negedge clock) begin : compare
    bit          exp_busy;
    bit          exp_run;
    int          g;
    int          idx;
    logic [N_REQ-1:0] exp_ready;
    longint      n;
    if (reset) begin
      m_run_left = 0;
      m_tok      = 0;
      m_ptr      = 0;
      m_total    = '0;
      hs_mask    = '0;
      checkOutput("rst_run_en", run_en, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done_valid", done_valid, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_cycles_total", cycles_total, 0);
    end else begin
      exp_busy = (m_run_left > 0) || m_tok;
      exp_run  = (m_run_left > 0) && !halt;
      g = -1;
      if (!exp_busy) begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_ready = (g >= 0) ? N_REQ'(1 << g) : '0;

      checkOutput("run_en", run_en, exp_run);
      checkOutput("busy", busy, exp_busy);
      checkOutput("done_valid", done_valid, m_tok);
      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("cycles_total", cycles_total, m_total);
      if (m_tok) begin
        checkOutput("done_id", done_id, m_tok_id);
        checkOutput("done_remain", done_remain, m_tok_rem);
      end

      hs_mask = exp_ready;
      if (m_tok && done_ready) m_tok = 0;
      if (exp_run) begin
        m_total    = m_total + 1;
        m_run_left = m_run_left - 1;
        if (m_run_left == 0) begin
          m_tok = 1; m_tok_id = m_job; m_tok_rem = 0;
        end
      end else if (m_run_left > 0) begin
        m_tok = 1; m_tok_id = m_job; m_tok_rem = m_run_left;
        m_run_left = 0;
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % N_REQ;
        grant_log.push_back(g);
        m_job = g;
        n = longint'(req_cycles[g*CNT_W +: CNT_W]);
        if (n == 0) begin
          m_tok = 1; m_tok_id = g; m_tok_rem = 0;
        end else begin
          m_run_left = n;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N_REQ-1:0] v, input int c0, input int c1);
    req_valid = v;
    req_cycles[0*CNT_W +: CNT_W] = CNT_W'(c0);
    req_cycles[1*CNT_W +: CNT_W] = CNT_W'(c1);
  endtask

  // Returns after the handshake edge (+1); counts a timeout as a failure.
  task automatic waitGrant(output int id);
    logic [N_REQ-1:0] r;
    id = -1;
    for (int c = 0; c < 50; c++) begin
      #1;
      r = req_ready;
      @(posedge clock);
      #1;
      if (r != '0) begin
        id = r[1] ? 1 : 0;
        return;
      end
    end
    checkOutput("grant_timeout", 0, 1);
  endtask

  // Counts run_en cycles until the token appears; optionally halts on cycle halt_at.
  task automatic runToDone(input int halt_at, output int runs);
    runs = 0;
    for (int c = 1; c < 200; c++) begin
      halt = (c == halt_at);
      #1;
      if (done_valid) begin
        halt = 1'b0;
        return;
      end
      if (run_en) runs++;
      @(posedge clock);
      #1;
    end
    halt = 1'b0;
    checkOutput("done_timeout", 0, 1);
  endtask

  task automatic consume();
    done_ready = 1'b1;
    @(posedge clock);
    #1;
    done_ready = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int id;
    int runs;
    int start;
    reset      = 1'b0;
    halt       = 1'b0;
    done_ready = 1'b0;
    applyStimulus('0, 0, 0);
    #2;
    applyReset();

    // Single request of 5 cycles from requester 0.
    applyStimulus(2'b01, 5, 0);
    waitGrant(id);
    req_valid = '0;
    checkOutput("t1_grant_id", id, 0);
    runToDone(0, runs);
    checkOutput("t1_runs", runs, 5);
    checkOutput("t1_done_id", done_id, 0);
    checkOutput("t1_done_remain", done_remain, 0);
    checkOutput("t1_total", cycles_total, 5);
    consume();

    // Two competing requesters alternate, starting from 0 after reset.
    applyReset();
    start = grant_log.size();
    applyStimulus(2'b11, 3, 3);
    for (int k = 0; k < 4; k++) begin
      waitGrant(id);
      checkOutput("t2_order", id, k % 2);
      runToDone(0, runs);
      checkOutput("t2_runs", runs, 3);
      consume();
    end
    req_valid = '0;
    checkOutput("t2_total", cycles_total, 12);
    checkOutput("t2_model_total", m_total, 12);
    checkOutput("t2_model_len", grant_log.size() - start, 4);
    for (int k = 0; k < 4; k++) checkOutput("t2_model_order", grant_log[start + k], k % 2);

    // Halt on the 4th RUN cycle of a 10-cycle run.
    applyStimulus(2'b01, 10, 0);
    waitGrant(id);
    req_valid = '0;
    runToDone(4, runs);
    checkOutput("t3_runs", runs, 3);
    checkOutput("t3_done_remain", done_remain, 7);
    checkOutput("t3_total", cycles_total, 15);
    consume();

    // Zero-cycle request completes immediately.
    applyStimulus(2'b01, 0, 0);
    waitGrant(id);
    req_valid = '0;
    #1;
    checkOutput("t4_done_next", done_valid, 1);
    checkOutput("t4_run_en", run_en, 0);
    checkOutput("t4_done_remain", done_remain, 0);
    checkOutput("t4_total", cycles_total, 15);
    consume();

    // Token held for 8 cycles while both requesters wait.
    applyStimulus(2'b10, 0, 1);
    waitGrant(id);
    checkOutput("t5_grant_id", id, 1);
    applyStimulus(2'b11, 2, 1);
    runToDone(0, runs);
    checkOutput("t5_runs", runs, 1);
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("t5_hold_ready", req_ready, 0);
      checkOutput("t5_hold_valid", done_valid, 1);
      checkOutput("t5_hold_id", done_id, 1);
      checkOutput("t5_hold_remain", done_remain, 0);
      @(posedge clock);
      #1;
    end
    done_ready = 1'b1;
    #1;
    checkOutput("t5_hs_ready", req_ready, 0);
    @(posedge clock);
    #1;
    done_ready = 1'b0;
    #1;
    checkOutput("t5_idle_busy", busy, 0);
    checkOutput("t5_idle_ready", req_ready, 2'b01);
    waitGrant(id);
    req_valid = '0;
    checkOutput("t5_next_id", id, 0);
    runToDone(0, runs);
    checkOutput("t5_next_runs", runs, 2);
    checkOutput("t5_total", cycles_total, 18);
    consume();

    // Asynchronous reset in the middle of a 20-cycle run.
    applyStimulus(2'b01, 20, 0);
    waitGrant(id);
    req_valid = '0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_run_en_async", run_en, 0);
    checkOutput("t6_done_valid", done_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_total", cycles_total, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(2'b10, 0, 2);
    waitGrant(id);
    req_valid = '0;
    checkOutput("t6_grant_id", id, 1);
    runToDone(0, runs);
    checkOutput("t6_runs", runs, 2);
    checkOutput("t6_done_id", done_id, 1);
    checkOutput("t6_total_after", cycles_total, 2);
    consume();

    // Randomized traffic; requesters hold their count while valid.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs_mask[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_cycles[i*CNT_W +: CNT_W] = ($urandom_range(0, 9) == 0) ?
                                         CNT_W'($urandom_range(0, 25)) :
                                         CNT_W'($urandom_range(0, 6));
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      halt       = ($urandom_range(0, 7) == 0);
      done_ready = $urandom_range(0, 1) == 1;
    end
    @(posedge clock);
    #1;
    req_valid  = '0;
    halt       = 1'b0;
    done_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
